turf_event_fragment_tx: RTL and testbench
=========================================

Name: turf_event_fragment_tx

Overview:
- Event-data transmitter that consumes the settings produced by the TURF event control port:
  - destination IP and port
  - open/closed flag
  - fragment length, in qwords minus one
- Takes a 64-bit AXI4-Stream of event words, one `tlast` per event, and cuts each event into UDP fragments.
- Each fragment is one header qword plus up to N data qwords.
- Fragments are emitted on the UDP header/data AXI4-Stream pair into the UDP transmit path.
- One fragment is buffered internally, so the UDP length is known before the header is sent.

Parameters:
- MAX_FRAG_WORDS, 1024, depth of the fragment buffer in qwords; must be ≥ 2^10.
- BUF_ADDR_BITS, 10, buffer address width, equal to log2(MAX_FRAG_WORDS).

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  reset, synchronous, active-high.
- s_ev_tdata  in  64  event data.
- s_ev_tkeep  in  8  byte enables; 8'hFF except on the tlast word, where they are contiguous from bit 0 and non-zero.
- s_ev_tlast  in  1  last word of an event.
- s_ev_tvalid  in  1  event data valid.
- s_ev_tready  out  1  event data ready.
- m_udphdr_tdata  out  64  {ip[31:0], port[15:0], length[15:0]}.
- m_udphdr_tvalid  out  1  header valid.
- m_udphdr_tready  in  1  header ready.
- m_udpdata_tdata  out  64  fragment payload.
- m_udpdata_tkeep  out  8  payload byte enables.
- m_udpdata_tlast  out  1  last payload word of the fragment.
- m_udpdata_tvalid  out  1  payload valid.
- m_udpdata_tready  in  1  payload ready.
- nfragment_count_i  in  10  fragment data qwords minus one.
- event_ip_i  in  32  destination IP.
- event_port_i  in  16  destination port.
- event_open_i  in  1  transmit enable.
- event_count_o  out  32  events seen, sent or dropped.
- drop_count_o  out  32  events dropped because the port was closed.

Behaviour:
- Reset:
  - State goes to IDLE; the buffer is emptied.
  - All tvalid outputs and s_ev_tready go to 0.
  - event_count_o, drop_count_o, the fragment index and the latched settings all clear to 0.
  - Reset mid-event: buffered data is discarded. The next s_ev word accepted after reset is treated as the start of a new event.
- Latching settings: on the first word of each event, the block latches ip, port, F = nfragment_count_i + 1, and the open flag. Later input changes do not affect that event.
- State machine:
  - IDLE:
    - s_ev_tready = 0.
    - If s_ev_tvalid, latch the settings and go to FILL if open, otherwise DROP.
  - DROP:
    - s_ev_tready = 1; words are discarded.
    - On tvalid&tlast: drop_count++, event_count++, go to IDLE.
  - FILL:
    - s_ev_tready = 1; each accepted word is written to buffer[wcnt], and wcnt++.
    - On a tlast word: record its tkeep, set last_flag = 1, go to HDR.
    - If wcnt reaches F without tlast: set last_flag = 0, go to HDR.
    - A tlast landing exactly on word F gives last_flag = 1. No empty trailing fragment is produced.
  - HDR:
    - m_udphdr_tvalid = 1.
    - length = 8 + 8*(nwords−1) + popcount(last_keep). last_keep is 8'hFF for non-final fragments.
    - On tready, go to TXHQ.
  - TXHQ:
    - m_udpdata_tvalid = 1.
    - tdata = {event_count[31:0], frag_idx[15:0], 15'b0, last_flag}, tkeep = FF, tlast = 0.
    - On tready, go to TXDATA.
  - TXDATA:
    - Streams buffer[0..nwords−1] with tkeep = FF, except the final word, which carries last_keep.
    - tlast is asserted on word nwords−1.
    - Sustains one word per cycle while tready is held high. tvalid never drops mid-packet.
    - After the final handshake:
      - If last_flag: event_count++, frag_idx = 0, go to IDLE.
      - Otherwise: frag_idx++, wcnt = 0, go to FILL with the same latched settings.
- Flow control:
  - s_ev_tready is 0 outside FILL and DROP; input is never accepted while a fragment is being transmitted.
  - tvalid outputs never depend combinationally on tready.
- Widths and wrap:
  - frag_idx is 16-bit and wraps.
  - Both counters are 32-bit and wrap at 2^32.
  - length is 16-bit; the maximum is 8 + 8192 = 8200.
- event_open_i falling mid-event has no effect; the current event completes.

Decomposition:
- Package turf_event_pkg:
  - FSM state enum.
  - Header-qword field offsets.
  - UDP_HDR_BYTES = 8.
- Sub-module turf_frag_buffer: simple dual-port 2^BUF_ADDR_BITS × 64 RAM with a registered read. The read prefetch/skid logic stays in the parent.

Test Plan:
- Single short event:
  - Stimulus: open, IP 0x0A000001, port 0x5000, nfragment 127; event of 3 words with last tkeep 8'h0F.
  - Response: one header {0A000001, 5000, 0x001C}, then header qword flag = 1, then 3 words with tlast on the third and tkeep 0F on it.
- Exact boundary:
  - Stimulus: nfragment 3 (F = 4); event of 8 full words.
  - Response: two fragments, each of length 40. frag_idx is 0 then 1; last_flag is 0 then 1.
- Closed port:
  - Stimulus: event_open_i = 0; a 5-word event.
  - Response: no m_ traffic; drop_count_o = 1; event_count_o = 1.
- Backpressure:
  - Stimulus: m_udpdata_tready toggles randomly at 50% over a 130-word event with F = 128.
  - Response: data ordering is preserved; tvalid is stable until handshake; fragments have lengths 1032 and 24.
- Settings change mid-event:
  - Stimulus: event_port_i changes from 0x5000 to 0x6000 after the first word of a multi-fragment event.
  - Response: every fragment of that event uses 0x5000; the next event uses 0x6000.
- Reset mid-FILL:
  - Stimulus: assert areset for 1 cycle after 2 words are accepted.
  - Response: no output; counters read 0; the next event transmits normally with frag_idx = 0.

Source files
------------

// File: rtl/turf_event_pkg.sv
// Shared types and field layout for the TURF event fragment transmitter.
// The FSM states, UDP header/header-qword bit offsets and the UDP length helper live here.
package turf_event_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DROP   = 3'd1,
        ST_FILL   = 3'd2,
        ST_HDR    = 3'd3,
        ST_TXHQ   = 3'd4,
        ST_TXDATA = 3'd5
    } state_t;

    localparam int QWORD_W       = 64;
    localparam int KEEP_W        = 8;
    localparam int UDP_HDR_BYTES = 8;

    // UDP header word: {ip, port, length}
    localparam int HDR_IP_LSB   = 32;
    localparam int HDR_PORT_LSB = 16;
    localparam int HDR_LEN_LSB  = 0;

    // Header qword leading each fragment payload: {event_count, frag_idx, 15'b0, last_flag}
    localparam int HQ_EVCNT_LSB = 32;
    localparam int HQ_FIDX_LSB  = 16;
    localparam int HQ_LAST_BIT  = 0;

    function automatic logic [3:0] popcount8(input logic [KEEP_W-1:0] keep);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < KEEP_W; i++) begin
            cnt = cnt + 4'(keep[i]);
        end
        return cnt;
    endfunction

    // nwords counts the payload qwords (>= 1); only the final one may be partial.
    function automatic logic [15:0] udp_len(input logic [15:0] nwords,
                                            input logic [KEEP_W-1:0] last_keep);
        return 16'(UDP_HDR_BYTES) + ((nwords - 16'd1) << 3) + 16'(popcount8(last_keep));
    endfunction

endpackage

// File: rtl/turf_frag_buffer.sv
// Simple dual-port fragment RAM: one write port, one read port with a registered output.
// Contents are never reset; the parent tracks which words are valid.
module turf_frag_buffer #(
    parameter int MAX_FRAG_WORDS = 1024,
    parameter int BUF_ADDR_BITS  = 10,
    parameter int DATA_W         = 64
) (
    input  logic                     aclk,
    input  logic                     wr_en,
    input  logic [BUF_ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [BUF_ADDR_BITS-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data_p1
);

    logic [DATA_W-1:0] mem [MAX_FRAG_WORDS];

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_p1 <= mem[rd_addr];
    end

endmodule

// File: rtl/turf_event_fragment_tx.sv
// Cuts each incoming event into UDP fragments: one fragment is buffered so its length is
// known, then a UDP header, a header qword and the buffered payload are transmitted.
module turf_event_fragment_tx
    import turf_event_pkg::*;
#(
    parameter int MAX_FRAG_WORDS = 1024,
    parameter int BUF_ADDR_BITS  = 10
) (
    input  logic        aclk,
    input  logic        areset,

    input  logic [63:0] s_ev_tdata,
    input  logic [7:0]  s_ev_tkeep,
    input  logic        s_ev_tlast,
    input  logic        s_ev_tvalid,
    output logic        s_ev_tready,

    output logic [63:0] m_udphdr_tdata,
    output logic        m_udphdr_tvalid,
    input  logic        m_udphdr_tready,

    output logic [63:0] m_udpdata_tdata,
    output logic [7:0]  m_udpdata_tkeep,
    output logic        m_udpdata_tlast,
    output logic        m_udpdata_tvalid,
    input  logic        m_udpdata_tready,

    input  logic [9:0]  nfragment_count_i,
    input  logic [31:0] event_ip_i,
    input  logic [15:0] event_port_i,
    input  logic        event_open_i,
    output logic [31:0] event_count_o,
    output logic [31:0] drop_count_o
);

    localparam int CW = BUF_ADDR_BITS + 1;
    typedef logic [CW-1:0] cnt_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] ip_q;
    logic [15:0] port_q;
    cnt_t        f_q;
    cnt_t        wcnt;
    cnt_t        wcnt_inc;
    cnt_t        nwords_q;
    cnt_t        rd_idx;
    cnt_t        rd_nxt;
    logic [7:0]  last_keep_q;
    logic        last_flag_q;
    logic [15:0] frag_idx;
    logic [31:0] event_cnt;
    logic [31:0] drop_cnt;

    logic        ev_hs;
    logic        rd_last;
    logic [15:0] frag_len;
    logic [63:0] hdr_word;
    logic [63:0] hq_word;
    logic [63:0] ram_rdata_p1;

    assign ev_hs    = s_ev_tvalid & s_ev_tready;
    assign wcnt_inc = wcnt + cnt_t'(1);
    assign rd_last  = (rd_idx == nwords_q - cnt_t'(1));
    // RAM address runs one word ahead of the handshake so the registered read keeps pace.
    assign rd_nxt   = rd_idx + cnt_t'(m_udpdata_tready);
    assign frag_len = udp_len(16'(nwords_q), last_keep_q);

    assign event_count_o = event_cnt;
    assign drop_count_o  = drop_cnt;

    always_comb begin
        hdr_word = '0;
        hdr_word[HDR_IP_LSB   +: 32] = ip_q;
        hdr_word[HDR_PORT_LSB +: 16] = port_q;
        hdr_word[HDR_LEN_LSB  +: 16] = frag_len;
        hq_word = '0;
        hq_word[HQ_EVCNT_LSB +: 32] = event_cnt;
        hq_word[HQ_FIDX_LSB  +: 16] = frag_idx;
        hq_word[HQ_LAST_BIT]        = last_flag_q;
    end

    assign m_udphdr_tdata = hdr_word;

    turf_frag_buffer #(
        .MAX_FRAG_WORDS (MAX_FRAG_WORDS),
        .BUF_ADDR_BITS  (BUF_ADDR_BITS),
        .DATA_W         (QWORD_W)
    ) u_buf (
        .aclk       (aclk),
        .wr_en      (ev_hs && (state == ST_FILL)),
        .wr_addr    (wcnt[BUF_ADDR_BITS-1:0]),
        .wr_data    (s_ev_tdata),
        .rd_addr    ((state == ST_TXDATA) ? rd_nxt[BUF_ADDR_BITS-1:0] : '0),
        .rd_data_p1 (ram_rdata_p1)
    );

    always_comb begin
        state_nxt        = state;
        s_ev_tready      = 1'b0;
        m_udphdr_tvalid  = 1'b0;
        m_udpdata_tvalid = 1'b0;
        m_udpdata_tdata  = '0;
        m_udpdata_tkeep  = 8'hFF;
        m_udpdata_tlast  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (s_ev_tvalid) begin
                    state_nxt = event_open_i ? ST_FILL : ST_DROP;
                end
            end
            ST_DROP: begin
                s_ev_tready = 1'b1;
                if (s_ev_tvalid && s_ev_tlast) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FILL: begin
                s_ev_tready = 1'b1;
                if (ev_hs && (s_ev_tlast || (wcnt_inc == f_q))) begin
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                m_udphdr_tvalid = 1'b1;
                if (m_udphdr_tready) begin
                    state_nxt = ST_TXHQ;
                end
            end
            ST_TXHQ: begin
                m_udpdata_tvalid = 1'b1;
                m_udpdata_tdata  = hq_word;
                if (m_udpdata_tready) begin
                    state_nxt = ST_TXDATA;
                end
            end
            ST_TXDATA: begin
                m_udpdata_tvalid = 1'b1;
                m_udpdata_tdata  = ram_rdata_p1;
                m_udpdata_tkeep  = rd_last ? last_keep_q : 8'hFF;
                m_udpdata_tlast  = rd_last;
                if (m_udpdata_tready && rd_last) begin
                    state_nxt = last_flag_q ? ST_IDLE : ST_FILL;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= ST_IDLE;
            ip_q        <= '0;
            port_q      <= '0;
            f_q         <= '0;
            wcnt        <= '0;
            nwords_q    <= '0;
            rd_idx      <= '0;
            last_keep_q <= '0;
            last_flag_q <= 1'b0;
            frag_idx    <= '0;
            event_cnt   <= '0;
            drop_cnt    <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                ST_IDLE: begin
                    if (s_ev_tvalid) begin
                        ip_q     <= event_ip_i;
                        port_q   <= event_port_i;
                        f_q      <= cnt_t'(nfragment_count_i) + cnt_t'(1);
                        wcnt     <= '0;
                        frag_idx <= '0;
                    end
                end
                ST_DROP: begin
                    if (ev_hs && s_ev_tlast) begin
                        drop_cnt  <= drop_cnt + 32'd1;
                        event_cnt <= event_cnt + 32'd1;
                    end
                end
                ST_FILL: begin
                    if (ev_hs) begin
                        wcnt        <= wcnt_inc;
                        nwords_q    <= wcnt_inc;
                        last_keep_q <= s_ev_tlast ? s_ev_tkeep : 8'hFF;
                        last_flag_q <= s_ev_tlast;
                    end
                end
                ST_HDR: begin
                    rd_idx <= '0;
                end
                ST_TXHQ: begin
                    rd_idx <= '0;
                end
                ST_TXDATA: begin
                    rd_idx <= rd_nxt;
                    if (m_udpdata_tready && rd_last) begin
                        if (last_flag_q) begin
                            event_cnt <= event_cnt + 32'd1;
                            frag_idx  <= '0;
                        end else begin
                            frag_idx <= frag_idx + 16'd1;
                            wcnt     <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_turf_event_fragment_tx.sv
// Directed bench for turf_event_fragment_tx: single event, exact fragment boundary,
// closed port, payload backpressure, settings change mid-event and reset mid-fill.
module tb_turf_event_fragment_tx;

    logic        aclk = 1'b0;
    logic        areset;
    logic [63:0] ev_tdata;
    logic [7:0]  ev_tkeep;
    logic        ev_tlast;
    logic        ev_tvalid;
    logic        ev_tready;
    logic [63:0] hdr_tdata;
    logic        hdr_tvalid;
    logic        hdr_tready;
    logic [63:0] dat_tdata;
    logic [7:0]  dat_tkeep;
    logic        dat_tlast;
    logic        dat_tvalid;
    logic        dat_tready;
    logic [9:0]  nfrag;
    logic [31:0] ip;
    logic [15:0] port;
    logic        open;
    logic [31:0] event_count;
    logic [31:0] drop_count;

    int ncmp = 0;
    int nfail = 0;
    int hdr_hs = 0;
    int dat_hs = 0;
    int h0;
    int d0;

    turf_event_fragment_tx dut (
        .aclk              (aclk),
        .areset            (areset),
        .s_ev_tdata        (ev_tdata),
        .s_ev_tkeep        (ev_tkeep),
        .s_ev_tlast        (ev_tlast),
        .s_ev_tvalid       (ev_tvalid),
        .s_ev_tready       (ev_tready),
        .m_udphdr_tdata    (hdr_tdata),
        .m_udphdr_tvalid   (hdr_tvalid),
        .m_udphdr_tready   (hdr_tready),
        .m_udpdata_tdata   (dat_tdata),
        .m_udpdata_tkeep   (dat_tkeep),
        .m_udpdata_tlast   (dat_tlast),
        .m_udpdata_tvalid  (dat_tvalid),
        .m_udpdata_tready  (dat_tready),
        .nfragment_count_i (nfrag),
        .event_ip_i        (ip),
        .event_port_i      (port),
        .event_open_i      (open),
        .event_count_o     (event_count),
        .drop_count_o      (drop_count)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (hdr_tvalid && hdr_tready) hdr_hs <= hdr_hs + 1;
        if (dat_tvalid && dat_tready) dat_hs <= dat_hs + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n;
        n = 0;
        ev_tdata  = d;
        ev_tkeep  = k;
        ev_tlast  = l;
        ev_tvalid = 1'b1;
        while (ev_tready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("push_ready", {63'b0, ev_tready}, 64'd1);
        tick();
        ev_tvalid = 1'b0;
        ev_tlast  = 1'b0;
    endtask

    task automatic push_range(input logic [31:0] tag, input int a, input int b,
                              input logic [7:0] lk, input bit has_last);
        for (int i = a; i <= b; i++) begin
            if (has_last && i == b) push({tag, 32'(i)}, lk, 1'b1);
            else                    push({tag, 32'(i)}, 8'hFF, 1'b0);
        end
    endtask

    task automatic check_frag(input string tag, input logic [31:0] eip, input logic [15:0] eport,
                              input logic [15:0] len, input logic [31:0] evc,
                              input logic [15:0] fidx, input logic lf, input logic [31:0] dtag,
                              input int first, input int n, input logic [7:0] lkeep, input bit bp);
        int w;
        int cyc;
        logic rdy;
        logic [63:0] ed;
        logic [7:0] ek;
        logic el;
        cyc = 0;
        while (hdr_tvalid !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk({tag, "_hdr_valid"}, {63'b0, hdr_tvalid}, 64'd1);
        if (hdr_tvalid !== 1'b1) return;
        chk({tag, "_hdr"}, hdr_tdata, {eip, eport, len});
        tick();
        w = 0;
        cyc = 0;
        while (w <= n && cyc < 4000) begin
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            dat_tready = rdy;
            if (w == 0) begin
                ed = {evc, fidx, 15'b0, lf};
                ek = 8'hFF;
                el = 1'b0;
            end else begin
                ed = {dtag, 32'(first + w - 1)};
                ek = (w == n) ? lkeep : 8'hFF;
                el = (w == n);
            end
            chk({tag, "_dvalid"}, {63'b0, dat_tvalid}, 64'd1);
            chk({tag, "_data"}, dat_tdata, ed);
            chk({tag, "_keep"}, {56'b0, dat_tkeep}, {56'b0, ek});
            chk({tag, "_last"}, {63'b0, dat_tlast}, {63'b0, el});
            tick();
            cyc++;
            if (rdy) w++;
        end
        dat_tready = 1'b1;
        chk({tag, "_after"}, {63'b0, dat_tvalid}, 64'd0);
    endtask

    initial begin
        areset     = 1'b1;
        ev_tdata   = '0;
        ev_tkeep   = '0;
        ev_tlast   = 1'b0;
        ev_tvalid  = 1'b0;
        hdr_tready = 1'b1;
        dat_tready = 1'b1;
        nfrag      = '0;
        ip         = '0;
        port       = '0;
        open       = 1'b0;
        repeat (3) tick();
        areset = 1'b0;
        tick();

        chk("rst_ev_tready",  {63'b0, ev_tready},  64'd0);
        chk("rst_hdr_tvalid", {63'b0, hdr_tvalid}, 64'd0);
        chk("rst_dat_tvalid", {63'b0, dat_tvalid}, 64'd0);
        chk("rst_event_cnt",  {32'b0, event_count}, 64'd0);
        chk("rst_drop_cnt",   {32'b0, drop_count},  64'd0);

        // Single short event: 3 words, last keep 0F -> length 8+16+4 = 28
        ip = 32'h0A00_0001; port = 16'h5000; nfrag = 10'd127; open = 1'b1;
        push_range(32'h1, 0, 2, 8'h0F, 1'b1);
        check_frag("single", 32'h0A00_0001, 16'h5000, 16'h001C, 32'd0, 16'd0, 1'b1,
                   32'h1, 0, 3, 8'h0F, 1'b0);
        chk("single_evcnt", {32'b0, event_count}, 64'd1);

        // Exact boundary: F = 4, 8 full words -> two fragments of length 40
        nfrag = 10'd3;
        push_range(32'h2, 0, 3, 8'hFF, 1'b0);
        check_frag("bnd0", 32'h0A00_0001, 16'h5000, 16'd40, 32'd1, 16'd0, 1'b0,
                   32'h2, 0, 4, 8'hFF, 1'b0);
        push_range(32'h2, 4, 7, 8'hFF, 1'b1);
        check_frag("bnd1", 32'h0A00_0001, 16'h5000, 16'd40, 32'd1, 16'd1, 1'b1,
                   32'h2, 4, 4, 8'hFF, 1'b0);
        chk("bnd_evcnt", {32'b0, event_count}, 64'd2);

        // Closed port: 5-word event dropped, no m_ traffic
        open = 1'b0;
        h0 = hdr_hs;
        d0 = dat_hs;
        push_range(32'h3, 0, 4, 8'h07, 1'b1);
        repeat (5) tick();
        chk("drop_no_hdr",  64'(hdr_hs), 64'(h0));
        chk("drop_no_data", 64'(dat_hs), 64'(d0));
        chk("drop_cnt",     {32'b0, drop_count},  64'd1);
        chk("drop_evcnt",   {32'b0, event_count}, 64'd3);
        open = 1'b1;

        // Backpressure: F = 128, 130 words -> lengths 1032 and 24
        nfrag = 10'd127;
        push_range(32'h4, 0, 127, 8'hFF, 1'b0);
        check_frag("bp0", 32'h0A00_0001, 16'h5000, 16'd1032, 32'd3, 16'd0, 1'b0,
                   32'h4, 0, 128, 8'hFF, 1'b1);
        push_range(32'h4, 128, 129, 8'hFF, 1'b1);
        check_frag("bp1", 32'h0A00_0001, 16'h5000, 16'd24, 32'd3, 16'd1, 1'b1,
                   32'h4, 128, 2, 8'hFF, 1'b1);
        chk("bp_evcnt", {32'b0, event_count}, 64'd4);

        // Port changes after first word: whole event keeps 0x5000, next event uses 0x6000
        nfrag = 10'd1;
        port = 16'h5000;
        push({32'h5, 32'd0}, 8'hFF, 1'b0);
        port = 16'h6000;
        push({32'h5, 32'd1}, 8'hFF, 1'b0);
        check_frag("chg0", 32'h0A00_0001, 16'h5000, 16'd24, 32'd4, 16'd0, 1'b0,
                   32'h5, 0, 2, 8'hFF, 1'b0);
        push({32'h5, 32'd2}, 8'h03, 1'b1);
        check_frag("chg1", 32'h0A00_0001, 16'h5000, 16'd10, 32'd4, 16'd1, 1'b1,
                   32'h5, 2, 1, 8'h03, 1'b0);
        push({32'h6, 32'd0}, 8'hFF, 1'b1);
        check_frag("chg2", 32'h0A00_0001, 16'h6000, 16'd16, 32'd5, 16'd0, 1'b1,
                   32'h6, 0, 1, 8'hFF, 1'b0);
        chk("chg_evcnt", {32'b0, event_count}, 64'd6);

        // Reset after 2 words of a fill: nothing emitted, counters cleared
        nfrag = 10'd127;
        push_range(32'h7, 0, 1, 8'hFF, 1'b0);
        h0 = hdr_hs;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        repeat (3) tick();
        chk("rst2_evcnt",  {32'b0, event_count}, 64'd0);
        chk("rst2_drop",   {32'b0, drop_count},  64'd0);
        chk("rst2_tready", {63'b0, ev_tready},   64'd0);
        chk("rst2_hdrv",   {63'b0, hdr_tvalid},  64'd0);
        chk("rst2_no_hdr", 64'(hdr_hs), 64'(h0));
        push({32'h8, 32'd0}, 8'hFF, 1'b0);
        push({32'h8, 32'd1}, 8'h01, 1'b1);
        check_frag("rst2", 32'h0A00_0001, 16'h6000, 16'd17, 32'd0, 16'd0, 1'b1,
                   32'h8, 0, 2, 8'h01, 1'b0);
        chk("rst2_evcnt_after", {32'b0, event_count}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
